// File: rtl/mc_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memory.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic [2:0] state;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] jump;
  logic [1:0] branch;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_src;
  logic [2:0] alu_op;
  logic       fault;

  modport master (
    output opcode, funct, mem_ready,
    input  state, ir_write, pc_write, pc_write_cond, jump, branch, mem_read, mem_write,
    input  reg_write, reg_dst, wd_sel, alu_src, alu_op, fault
  );

  modport slave (
    input  opcode, funct, mem_ready,
    output state, ir_write, pc_write, pc_write_cond, jump, branch, mem_read, mem_write,
    output reg_write, reg_dst, wd_sel, alu_src, alu_op, fault
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// wait timeout and a sticky fault that parks the machine in HALT until reset.
module mc_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic      clk,
  input logic      rstn,
  mc_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    InAddu, InSubu, InAnd, InOr, InSlt, InJr, InOri, InLui,
    InLw, InSw, InBeq, InBne, InJ, InJal, InIllegal
  } instr_e;

  state_e           state_q;
  logic             fault_q;
  logic             run_q;   // low until the first edge after reset release
  logic [WaitW-1:0] wait_q;
  instr_e           instr;
  logic             is_ctrl;
  logic             is_mem;
  logic             wait_expired;

  // Classify the instruction held in IR.
  always_comb begin
    instr = InIllegal;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h21:   instr = InAddu;
          6'h23:   instr = InSubu;
          6'h24:   instr = InAnd;
          6'h25:   instr = InOr;
          6'h2a:   instr = InSlt;
          6'h08:   instr = InJr;
          default: instr = InIllegal;
        endcase
      end
      6'h0d:   instr = InOri;
      6'h0f:   instr = InLui;
      6'h23:   instr = InLw;
      6'h2b:   instr = InSw;
      6'h04:   instr = InBeq;
      6'h05:   instr = InBne;
      6'h02:   instr = InJ;
      6'h03:   instr = InJal;
      default: instr = InIllegal;
    endcase
  end

  assign is_ctrl      = instr inside {InJr, InBeq, InBne, InJ, InJal};
  assign is_mem       = instr inside {InLw, InSw};
  assign wait_expired = (wait_q == WaitLast);

  // State sequencing, memory wait counting and sticky fault.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFetch;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
      wait_q  <= '0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (bus.mem_ready) begin
            state_q <= StDecode;
          end else if (wait_expired) begin
            fault_q <= 1'b1;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StDecode: begin
          wait_q <= '0;
          if (instr == InIllegal) begin
            fault_q <= 1'b1;
            state_q <= StHalt;
          end else if (is_ctrl) begin
            state_q <= StFetch;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          wait_q  <= '0;
          state_q <= is_mem ? StMem : StWb;
        end
        StMem: begin
          if (bus.mem_ready) begin
            wait_q  <= '0;
            state_q <= (instr == InLw) ? StWb : StFetch;
          end else if (wait_expired) begin
            fault_q <= 1'b1;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StWb: begin
          wait_q  <= '0;
          state_q <= StFetch;
        end
        StHalt: ;
        default: begin
          fault_q <= 1'b1;
          state_q <= StHalt;
        end
      endcase
    end
  end

  // Control strobes: Moore on state plus decode, FETCH load and MEM exit qualified by mem_ready.
  always_comb begin
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.jump          = 2'b00;
    bus.branch        = 2'b00;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.wd_sel        = 2'b00;
    bus.alu_src       = 1'b0;
    bus.alu_op        = 3'b000;
    if (run_q) begin
      unique case (state_q)
        StFetch: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        StDecode: begin
          case (instr)
            InJ:  begin bus.jump = 2'b01; bus.pc_write = 1'b1; end
            InJr: begin bus.jump = 2'b10; bus.pc_write = 1'b1; end
            InJal: begin
              bus.jump      = 2'b01;
              bus.pc_write  = 1'b1;
              bus.reg_write = 1'b1;
              bus.reg_dst   = 2'b10;
              bus.wd_sel    = 2'b10;
            end
            InBeq: begin bus.branch = 2'b01; bus.pc_write_cond = 1'b1; end
            InBne: begin bus.branch = 2'b10; bus.pc_write_cond = 1'b1; end
            default: ;
          endcase
        end
        StExec: begin
          case (instr)
            InSubu:     bus.alu_op = 3'b001;
            InAnd:      bus.alu_op = 3'b010;
            InOr:       bus.alu_op = 3'b011;
            InSlt:      bus.alu_op = 3'b100;
            InOri:      begin bus.alu_op = 3'b011; bus.alu_src = 1'b1; end
            InLui:      begin bus.alu_op = 3'b101; bus.alu_src = 1'b1; end
            InLw, InSw: begin bus.alu_op = 3'b000; bus.alu_src = 1'b1; end
            default:    bus.alu_op = 3'b000;
          endcase
        end
        StMem: begin
          bus.mem_read  = (instr == InLw);
          bus.mem_write = (instr == InSw);
        end
        StWb: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = (bus.opcode == 6'h00) ? 2'b01 : 2'b00;
          bus.wd_sel    = (instr == InLw) ? 2'b01 : 2'b00;
        end
        StHalt: ;
        default: ;
      endcase
    end
  end

  assign bus.state = state_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle traces built from a table of
// instruction attributes, replayed cycle by cycle against the DUT.
module tb_mc_ctrl;

  localparam int unsigned MaxWait = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mc_ctrl_if bus();

  mc_ctrl #(.MEM_WAIT_MAX(MaxWait)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       irw, pcw, pcc;
    logic [1:0] jmp, br;
    logic       mrd, mwr, rw;
    logic [1:0] rd, wd;
    logic       asrc;
    logic [2:0] aop;
    logic       flt;
  } out_t;

  // cls: 0 control transfer, 1 ALU write-back, 2 load, 3 store, 4 illegal
  typedef struct {
    string      name;
    logic [5:0] opc, fn;
    int         cls;
    logic [1:0] jmp, br, rd, wd;
    logic       asrc;
    logic [2:0] aop;
  } ins_t;

  typedef struct {
    string      name;
    logic       rdy;
    logic [5:0] opc, fn;
    out_t       o;
  } cyc_t;

  int   total = 0;
  int   bad = 0;
  cyc_t q[$];
  ins_t tbl[14];

  function automatic ins_t mk(string name, logic [5:0] opc, logic [5:0] fn, int cls,
                              logic [1:0] jmp, logic [1:0] br, logic [1:0] rd, logic [1:0] wd,
                              logic asrc, logic [2:0] aop);
    ins_t t;
    t.name = name; t.opc = opc; t.fn = fn; t.cls = cls; t.jmp = jmp; t.br = br;
    t.rd = rd; t.wd = wd; t.asrc = asrc; t.aop = aop;
    return t;
  endfunction

  function automatic out_t idle(logic [2:0] st);
    out_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic out_t observe();
    return {bus.state, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.jump, bus.branch,
            bus.mem_read, bus.mem_write, bus.reg_write, bus.reg_dst, bus.wd_sel, bus.alu_src,
            bus.alu_op, bus.fault};
  endfunction

  function automatic bit is_legal(logic [5:0] opc, logic [5:0] fn);
    foreach (tbl[i]) if (tbl[i].opc == opc && (opc != 6'h00 || tbl[i].fn == fn)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string tag, out_t obs, out_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s st=%0d observed=%h expected=%h", tag, exp.st, obs, exp);
    end
  endtask

  task automatic push(logic rdy, ins_t in, out_t o);
    cyc_t c;
    c.name = in.name; c.rdy = rdy; c.opc = in.opc; c.fn = in.fn; c.o = o;
    q.push_back(c);
  endtask

  task automatic push_halt(ins_t in);
    out_t o = idle(3'd7);
    o.flt = 1'b1;
    for (int i = 0; i < 3; i++) push(1'($urandom), in, o);
  endtask

  // Expected trace for one instruction with wf fetch waits and wm data waits.
  task automatic gen(ins_t in, int wf, int wm);
    out_t o;
    for (int i = 0; i < wf && i < int'(MaxWait); i++) begin
      o = idle(3'd0); o.mrd = 1'b1; push(1'b0, in, o);
    end
    if (wf >= int'(MaxWait)) begin push_halt(in); return; end
    o = idle(3'd0); o.mrd = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; push(1'b1, in, o);
    o = idle(3'd1);
    if (in.cls == 0) begin
      o.jmp = in.jmp; o.br = in.br;
      o.pcw = (in.jmp != 2'b00); o.pcc = (in.br != 2'b00);
      if (in.rd == 2'b10) begin o.rw = 1'b1; o.rd = in.rd; o.wd = in.wd; end
    end
    push(1'($urandom), in, o);
    if (in.cls == 0) return;
    if (in.cls == 4) begin push_halt(in); return; end
    o = idle(3'd2); o.asrc = in.asrc; o.aop = in.aop; push(1'($urandom), in, o);
    if (in.cls >= 2) begin
      o = idle(3'd3); o.mrd = (in.cls == 2); o.mwr = (in.cls == 3);
      for (int i = 0; i < wm && i < int'(MaxWait); i++) push(1'b0, in, o);
      if (wm >= int'(MaxWait)) begin push_halt(in); return; end
      push(1'b1, in, o);
      if (in.cls == 3) return;
    end
    o = idle(3'd4); o.rw = 1'b1; o.rd = in.rd; o.wd = in.wd; push(1'($urandom), in, o);
  endtask

  // Replay up to n queued cycles; entered and left just after a rising edge.
  task automatic run(int n);
    for (int k = 0; k < n && q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      #1;
      bus.mem_ready = c.rdy;
      if (c.o.st == 3'd0) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end else begin
        bus.opcode = c.opc;
        bus.funct  = c.fn;
      end
      @(negedge clk);
      check(c.name, observe(), c.o);
      @(posedge clk);
    end
    q.delete();
  endtask

  // Mid-cycle reset pulse; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1 check("reset", observe(), '0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    ins_t in;
    int   wf, wm;
    logic halted;
    tbl[0]  = mk("addu", 6'h00, 6'h21, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3'b000);
    tbl[1]  = mk("subu", 6'h00, 6'h23, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3'b001);
    tbl[2]  = mk("and",  6'h00, 6'h24, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3'b010);
    tbl[3]  = mk("or",   6'h00, 6'h25, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3'b011);
    tbl[4]  = mk("slt",  6'h00, 6'h2a, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3'b100);
    tbl[5]  = mk("jr",   6'h00, 6'h08, 0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000);
    tbl[6]  = mk("ori",  6'h0d, 6'h00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b011);
    tbl[7]  = mk("lui",  6'h0f, 6'h00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b101);
    tbl[8]  = mk("lw",   6'h23, 6'h00, 2, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 3'b000);
    tbl[9]  = mk("sw",   6'h2b, 6'h00, 3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000);
    tbl[10] = mk("beq",  6'h04, 6'h00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000);
    tbl[11] = mk("bne",  6'h05, 6'h00, 0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000);
    tbl[12] = mk("j",    6'h02, 6'h00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000);
    tbl[13] = mk("jal",  6'h03, 6'h00, 0, 2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000);

    rstn = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    @(posedge clk);
    do_reset();

    // Directed cases
    gen(tbl[0], 0, 0);  run(100);
    gen(tbl[8], 0, 3);  run(100);
    gen(tbl[11], 0, 0); gen(tbl[13], 0, 0); run(100);
    gen(mk("ill3f", 6'h3f, 6'h00, 4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000), 0, 0);
    run(100); do_reset();
    gen(mk("illfn", 6'h00, 6'h3f, 4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000), 0, 0);
    run(100); do_reset();
    gen(tbl[0], int'(MaxWait), 0); run(100); do_reset();
    gen(tbl[0], int'(MaxWait) - 1, 0); run(100);
    gen(tbl[8], 0, int'(MaxWait)); run(100); do_reset();
    gen(tbl[9], 1, int'(MaxWait) - 1); run(100);
    gen(tbl[0], 0, 0); run(2); do_reset();

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        in = mk("rnd_ill", 6'h3f, 6'h00, 4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000);
        for (int t = 0; t < 100; t++) begin
          in.opc = 6'($urandom);
          in.fn  = 6'($urandom);
          if (!is_legal(in.opc, in.fn)) break;
        end
        if (is_legal(in.opc, in.fn)) begin in.opc = 6'h3f; in.fn = 6'h00; end
      end else begin
        in = tbl[$urandom_range(0, 13)];
        if (in.opc != 6'h00) in.fn = 6'($urandom);
      end
      wf = ($urandom_range(0, 11) == 0) ? int'(MaxWait) : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 11) == 0) ? int'(MaxWait) : int'($urandom_range(0, 3));
      gen(in, wf, wm);
      halted = q[$].o.flt;
      run(100);
      if (halted) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum consecutive cycles waiting for mem_ready in FETCH or MEM before the block faults.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  IR[31:26], stable from the cycle after ir_write.
REQ-005 funct  input  6  IR[5:0].
REQ-006 mem_ready  input  1  memory done: instruction read in FETCH, data access in MEM.
REQ-007 state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-008 ir_write  output  1  load IR.
REQ-009 pc_write  output  1  unconditional PC load.
REQ-010 pc_write_cond  output  1  PC load, qualified externally by the NPC decision.
REQ-011 jump  output  2  to the NPC-select logic: 00 none, 01 immediate (j/jal), 10 register (jr).
REQ-012 branch  output  2  to the NPC-select logic: 00 none, 01 beq, 10 bne.
REQ-013 mem_read, mem_write  output  1 each  memory strobes.
REQ-014 reg_write  output  1  GPR write enable.
REQ-015 reg_dst  output  2  write register: 00 rt, 01 rd, 10 r31.
REQ-016 wd_sel  output  2  write data: 00 ALU, 01 memory, 10 PC (already +4).
REQ-017 alu_src  output  1  0 = GPR[rt], 1 = extended immediate.
REQ-018 alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 lui.
REQ-019 fault  output  1  sticky error flag; set on an illegal instruction or a memory timeout.

Function
REQ-020 Supported instructions:
- R-type (opcode 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000.
- I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
REQ-021 FETCH: mem_read=1.
- When mem_ready=1: ir_write=1, pc_write=1 with jump=branch=00 (PC+4), then go to DECODE.
- Otherwise stay in FETCH.
REQ-022 DECODE, by instruction class:
- j/jr: jump driven, pc_write=1, then FETCH.
- jal: jump=01, pc_write=1, reg_write=1, reg_dst=10, wd_sel=10, then FETCH.
- beq/bne: branch driven, pc_write_cond=1, then FETCH.
- All other legal instructions: go to EXEC.
REQ-023 EXEC: alu_src and alu_op driven for the decoded instruction.
- lw/sw: add with alu_src=1, then MEM.
- All others: go to WB.
REQ-024 MEM: lw asserts mem_read, sw asserts mem_write, both held until mem_ready.
- On mem_ready, lw goes to WB and sw goes to FETCH.
REQ-025 WB: reg_write=1, then FETCH.
- R-type: reg_dst=01, wd_sel=00.
- ori/lui: reg_dst=00, wd_sel=00.
- lw: reg_dst=00, wd_sel=01.
REQ-026 Outputs depend only on state, opcode and funct (Moore on state plus decode), with one exception: FETCH ir_write/pc_write and the MEM exit are qualified by mem_ready in the same cycle. Any strobe not listed for a state is 0.
REQ-027 Cycle counts, with zero memory wait: j/jr/jal/beq/bne 2; R-type, ori, lui, sw 4; lw 5. Each memory wait cycle adds 1.
REQ-028 Illegal opcode, or R-type with an unlisted funct, detected in DECODE: fault set, go to HALT, no strobes.
REQ-029 Wait counter:
- Clears on entering FETCH or MEM.
- Increments each cycle mem_ready=0 in those states.
- When it reaches MEM_WAIT_MAX with mem_ready still 0: fault set, go to HALT.
- mem_ready=1 in the same cycle the limit is reached still completes normally.
REQ-030 HALT: all strobes 0, jump=branch=00; exited only by reset.
REQ-031 jump and branch are nonzero only in DECODE, and never both nonzero at once.

Reset
REQ-032 While rstn=0, immediately and independent of clk: state=FETCH, fault=0, wait counter=0, all strobes 0, select outputs 0.
REQ-033 Reset asserted mid-instruction aborts it with no further strobes. The first edge after release begins FETCH.

Verification
REQ-034 addu (opcode 0, funct 21h), mem_ready always 1: states 0,1,2,4,0; reg_write=1 only in WB with reg_dst=01; 4 cycles total.
REQ-035 lw (23h), data mem_ready delayed 3 cycles: MEM held 4 cycles with mem_read=1; WB with wd_sel=01, reg_dst=00; 8 cycles total.
REQ-036 bne (05h): DECODE shows branch=10, pc_write_cond=1, pc_write=0; returns to FETCH after 2 cycles. jal (03h): jump=01, reg_write=1, reg_dst=10, wd_sel=10.
REQ-037 opcode 3Fh: fault=1 and state=7 on the edge after DECODE; rstn pulse low returns state=0, fault=0 without waiting for a clock.
REQ-038 MEM_WAIT_MAX=4, mem_ready held 0 in FETCH: HALT after 4 cycles. Repeat with mem_ready=1 on the 4th cycle: normal move to DECODE, fault=0.
